// File: rtl/boost_pkg.sv
// Shared definitions for the BOOST contingency table builder.
//   GENO_MISSING : genotype code that marks a missing call
//   NUM_JOINT    : joint table cells (2 pheno x 3 gb x 3 ga)
//   NUM_MARGIN   : SNP-A margin cells (2 pheno x 3 ga)
//   state_t      : builder FSM states
//   joint_idx    : flat joint cell index, pheno*9 + 3*gb + ga
//   margin_idx   : flat margin cell index, pheno*3 + ga
package boost_pkg;

    localparam logic [1:0] GENO_MISSING = 2'd3;
    localparam int NUM_JOINT  = 18;
    localparam int NUM_MARGIN = 6;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        OUTPUT = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    function automatic int unsigned joint_idx(input logic p, input logic [1:0] ga,
                                              input logic [1:0] gb);
        return 32'(p) * 32'd9 + 32'(gb) * 32'd3 + 32'(ga);
    endfunction

    function automatic int unsigned margin_idx(input logic p, input logic [1:0] ga);
        return 32'(p) * 32'd3 + 32'(ga);
    endfunction

endpackage

// File: rtl/table_counter.sv
// One saturating count cell of the contingency tables.
//   clk   : system clock
//   rst   : synchronous active-high reset, zeroes the cell
//   clear : synchronous clear between SNP pairs, zeroes the cell
//   inc   : add one this cycle (held at all-ones once saturated)
//   count : current cell value, straight from the register
module table_counter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [DATA_WIDTH-1:0] count
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/contingency_table_builder.sv
// Accumulates genotype/phenotype sample beats of one SNP pair into the joint
// table (2 pheno x 3x3) and the SNP-A margin table (2 pheno x 3), then
// presents both tables on one packed beat.
//   clk, rst          : clock, synchronous active-high reset
//   geno_a_in/b_in    : genotypes 0/1/2, 3 = missing
//   pheno_in          : 0 = control, 1 = case
//   data_valid_in     : sample beat valid
//   data_last_in      : final sample of the pair
//   data_ready_out    : sample beat accepted this cycle when valid
//   joint_table_out   : cell k = pheno*9 + 3*gb + ga, DATA_WIDTH bits each
//   margin_table_out  : cell k = pheno*3 + ga, DATA_WIDTH bits each
//   data_valid_out    : tables complete and stable
//   data_ready_in     : downstream consumes the tables
//
// Handshake: on both sides a beat transfers on a rising clk edge where valid
// and ready are both high. data_ready_out is high only in ACCUM and
// data_valid_out only in OUTPUT; both decode the state register alone, so no
// input reaches an output combinationally.
module contingency_table_builder
    import boost_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     geno_a_in,
    input  logic [1:0]                     geno_b_in,
    input  logic                           pheno_in,
    input  logic                           data_valid_in,
    input  logic                           data_last_in,
    output logic                           data_ready_out,
    output logic [NUM_JOINT*DATA_WIDTH-1:0]  joint_table_out,
    output logic [NUM_MARGIN*DATA_WIDTH-1:0] margin_table_out,
    output logic                           data_valid_out,
    input  logic                           data_ready_in
);

    state_t state;
    state_t state_next;
    logic   clear_cells;
    logic   count_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        data_ready_out = 1'b0;
        data_valid_out = 1'b0;
        clear_cells    = 1'b0;
        case (state)
            ACCUM: begin
                data_ready_out = 1'b1;
                if (data_valid_in && data_last_in) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                data_valid_out = 1'b1;
                if (data_ready_in) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clear_cells = 1'b1;
                state_next  = ACCUM;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // A sample with either genotype missing is accepted (its last flag still
    // closes the pair) but touches no cell, keeping margin = row sum of joint.
    assign count_en = data_valid_in && data_ready_out &&
                      (geno_a_in != GENO_MISSING) && (geno_b_in != GENO_MISSING);

    for (genvar k = 0; k < NUM_JOINT; k++) begin : g_joint
        logic inc;
        assign inc = count_en && (joint_idx(pheno_in, geno_a_in, geno_b_in) == k);
        table_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_cells),
            .inc   (inc),
            .count (joint_table_out[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    for (genvar k = 0; k < NUM_MARGIN; k++) begin : g_margin
        logic inc;
        assign inc = count_en && (margin_idx(pheno_in, geno_a_in) == k);
        table_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_cells),
            .inc   (inc),
            .count (margin_table_out[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
